// File: rtl/repetition_pkg.sv
// Shared definitions for the repetition-code transmit and receive stages.
// Holds the FSM encoding and the width and threshold helpers.
package repetition_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    // Smallest ones count that wins the vote; a tie on even n decodes to 0.
    function automatic int maj_threshold(input int n);
        return n / 2 + 1;
    endfunction

endpackage

// File: rtl/majority_group.sv
// Counts the copies of one repeated bit and votes on the current sample.
// The vote, disagree and tie outputs are meaningful only with group_done.
module majority_group
    import repetition_pkg::*;
#(
    parameter int N_REPT = 3
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic take,
    input  logic restart,
    input  logic bit_in,
    output logic group_done,
    output logic vote,
    output logic disagree,
    output logic tie
);

    localparam int CW = clog2(N_REPT + 1);

    logic [CW-1:0] rep_cnt;
    logic [CW-1:0] ones_cnt;
    logic [CW-1:0] cur_rep;
    logic [CW-1:0] ones_total;
    logic [CW:0]   twice;

    // A sync sample is always copy 0, whatever was counted before it.
    always_comb begin
        cur_rep    = (restart ? '0 : rep_cnt) + CW'(1);
        ones_total = (restart ? '0 : ones_cnt) + CW'(bit_in);
        twice      = {ones_total, 1'b0};
        group_done = take && (cur_rep == CW'(N_REPT));
        vote       = ones_total >= CW'(maj_threshold(N_REPT));
        disagree   = (ones_total != '0) && (ones_total != CW'(N_REPT));
        tie        = twice == (CW + 1)'(N_REPT);
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            rep_cnt  <= '0;
            ones_cnt <= '0;
        end else if (take) begin
            if (group_done) begin
                rep_cnt  <= '0;
                ones_cnt <= '0;
            end else begin
                rep_cnt  <= cur_rep;
                ones_cnt <= ones_total;
            end
        end
    end

endmodule

// File: rtl/repetition_decoder.sv
// Majority-vote decoder for a serial MSB-first repetition-coded stream.
// Rebuilds each word and flags corrected groups, ties and aborted frames.
module repetition_decoder
    import repetition_pkg::*;
#(
    parameter int N_REPT    = 3,
    parameter int N_BITS_IN = 8
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_valid,
    input  logic                 i_bit,
    input  logic                 i_sync,
    output logic [N_BITS_IN-1:0] o_bits,
    output logic                 o_valid,
    output logic                 o_corrected,
    output logic                 o_tie,
    output logic                 o_abort
);

    localparam int BW = clog2(N_BITS_IN + 1);

    state_t               state, state_nxt;
    logic [BW-1:0]        bit_cnt, bit_nxt;
    logic [N_BITS_IN-1:0] word, word_nxt;
    logic                 corr_f, corr_nxt;
    logic                 tie_f, tie_nxt;
    logic                 take, restart, deliver;
    logic                 group_done, vote, disagree, tie;

    assign restart = i_valid && i_sync;
    assign take    = i_valid && (i_sync || state == COLLECT);

    majority_group #(.N_REPT(N_REPT)) u_group (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .take       (take),
        .restart    (restart),
        .bit_in     (i_bit),
        .group_done (group_done),
        .vote       (vote),
        .disagree   (disagree),
        .tie        (tie)
    );

    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        word_nxt  = word;
        corr_nxt  = corr_f;
        tie_nxt   = tie_f;
        deliver   = 1'b0;
        if (take) begin
            state_nxt = COLLECT;
            // Resync discards everything gathered for the old frame.
            if (restart) begin
                bit_nxt  = '0;
                word_nxt = '0;
                corr_nxt = 1'b0;
                tie_nxt  = 1'b0;
            end
            if (group_done) begin
                word_nxt = (word_nxt << 1) | N_BITS_IN'(vote);
                corr_nxt = corr_nxt | disagree;
                tie_nxt  = tie_nxt | tie;
                bit_nxt  = bit_nxt + BW'(1);
                if (bit_nxt == BW'(N_BITS_IN)) begin
                    deliver   = 1'b1;
                    bit_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            word        <= '0;
            corr_f      <= 1'b0;
            tie_f       <= 1'b0;
            o_bits      <= '0;
            o_valid     <= 1'b0;
            o_corrected <= 1'b0;
            o_tie       <= 1'b0;
            o_abort     <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_nxt;
            word    <= word_nxt;
            corr_f  <= corr_nxt;
            tie_f   <= tie_nxt;
            o_valid <= deliver;
            o_abort <= restart && (state == COLLECT);
            if (deliver) begin
                o_bits      <= word_nxt;
                o_corrected <= corr_nxt;
                o_tie       <= tie_nxt;
            end
        end
    end

endmodule

// File: tb/tb_repetition_decoder.sv
// Directed bench for repetition_decoder: a vector table of whole frames
// plus hand-written gap, resync, reset and even-repetition sequences.
module tb_repetition_decoder;

    logic       clk;
    logic       rst;
    logic       v1, b1, s1;
    logic [3:0] bits1;
    logic       valid1, corr1, tie1, abort1;
    logic       v2, b2, s2;
    logic [2:0] bits2;
    logic       valid2, corr2, tie2, abort2;

    int n_pass, n_total;
    int n_valid, n_abort;

    typedef struct {
        logic [11:0] stream;
        logic [3:0]  bits;
        logic        corr;
    } vec_t;

    vec_t vecs[5];

    repetition_decoder #(.N_REPT(3), .N_BITS_IN(4)) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_valid     (v1),
        .i_bit       (b1),
        .i_sync      (s1),
        .o_bits      (bits1),
        .o_valid     (valid1),
        .o_corrected (corr1),
        .o_tie       (tie1),
        .o_abort     (abort1)
    );

    repetition_decoder #(.N_REPT(2), .N_BITS_IN(3)) dut_even (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_valid     (v2),
        .i_bit       (b2),
        .i_sync      (s2),
        .o_bits      (bits2),
        .o_valid     (valid2),
        .o_corrected (corr2),
        .o_tie       (tie2),
        .o_abort     (abort2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    // Drive one cycle from a falling edge; outputs are read at the next one.
    task automatic cyc(input logic v, input logic b, input logic s);
        v1 = v;
        b1 = b;
        s1 = s;
        @(negedge clk);
        n_valid += int'(valid1);
        n_abort += int'(abort1);
        v1 = 1'b0;
        s1 = 1'b0;
    endtask

    task automatic send_frame(input string name, input logic [11:0] st,
                              input int max_gap, input logic exp_abort,
                              input logic [3:0] eb, input logic ec,
                              input logic tail);
        n_valid = 0;
        n_abort = 0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0)
                repeat ($urandom_range(0, max_gap)) cyc(1'b0, 1'b0, 1'b0);
            cyc(1'b1, st[11-i], i == 0);
            if (i == 0)
                chk({name, "_abort"}, 32'(abort1), 32'(exp_abort));
        end
        chk({name, "_valid_now"}, 32'(valid1), 32'd1);
        chk({name, "_valid_cnt"}, n_valid, 32'd1);
        chk({name, "_bits"}, 32'(bits1), 32'(eb));
        chk({name, "_corr"}, 32'(corr1), 32'(ec));
        chk({name, "_tie"}, 32'(tie1), 32'd0);
        if (tail) begin
            cyc(1'b0, 1'b0, 1'b0);
            chk({name, "_valid_drop"}, 32'(valid1), 32'd0);
            chk({name, "_bits_hold"}, 32'(bits1), 32'(eb));
        end
    endtask

    task automatic send_even(input string name, input logic [5:0] st,
                             input logic [2:0] eb, input logic ec,
                             input logic et);
        for (int i = 0; i < 6; i++) begin
            v2 = 1'b1;
            b2 = st[5-i];
            s2 = (i == 0);
            @(negedge clk);
            if (i < 5)
                chk({name, "_early_valid"}, 32'(valid2), 32'd0);
        end
        v2 = 1'b0;
        s2 = 1'b0;
        chk({name, "_valid"}, 32'(valid2), 32'd1);
        chk({name, "_bits"}, 32'(bits2), 32'(eb));
        chk({name, "_corr"}, 32'(corr2), 32'(ec));
        chk({name, "_tie"}, 32'(tie2), 32'(et));
    endtask

    initial begin
        vecs[0] = '{12'b111_000_111_000, 4'b1010, 1'b0};
        vecs[1] = '{12'b110_001_111_010, 4'b1010, 1'b1};
        vecs[2] = '{12'b000_000_000_111, 4'b0001, 1'b0};
        vecs[3] = '{12'b101_010_101_010, 4'b1010, 1'b1};
        vecs[4] = '{12'b011_100_001_110, 4'b1001, 1'b1};

        n_pass  = 0;
        n_total = 0;
        n_valid = 0;
        n_abort = 0;
        v1 = 0; b1 = 0; s1 = 0;
        v2 = 0; b2 = 0; s2 = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_bits", 32'(bits1), 32'd0);
        chk("rst_flags", {28'd0, valid1, corr1, tie1, abort1}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[k])
            send_frame($sformatf("vec%0d", k), vecs[k].stream, 0, 1'b0,
                       vecs[k].bits, vecs[k].corr, 1'b1);

        send_frame("b2b_a", 12'b111_000_111_000, 0, 1'b0, 4'b1010, 1'b0, 1'b0);
        send_frame("b2b_b", 12'b000_000_000_111, 0, 1'b0, 4'b0001, 1'b0, 1'b1);

        send_frame("gap", 12'b111_000_111_000, 5, 1'b0, 4'b1010, 1'b0, 1'b1);

        n_valid = 0;
        n_abort = 0;
        for (int i = 0; i < 7; i++)
            cyc(1'b1, i < 3, i == 0);
        chk("resync_partial_valid", n_valid, 32'd0);
        send_frame("resync", 12'b000_000_000_111, 0, 1'b1, 4'b0001, 1'b0, 1'b1);

        n_valid = 0;
        n_abort = 0;
        for (int i = 0; i < 11; i++)
            cyc(1'b1, 1'b1, i == 0);
        send_frame("last_sync", 12'b111_000_111_000, 0, 1'b1, 4'b1010, 1'b0, 1'b1);

        n_valid = 0;
        n_abort = 0;
        for (int i = 0; i < 6; i++)
            cyc(1'b1, i[0], 1'b0);
        chk("stray_valid", n_valid, 32'd0);
        chk("stray_abort", n_abort, 32'd0);

        n_valid = 0;
        n_abort = 0;
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 1'b1, i == 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_bits", 32'(bits1), 32'd0);
        chk("arst_flags", {28'd0, valid1, corr1, tie1, abort1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        chk("arst_no_abort", n_abort, 32'd0);
        send_frame("post_rst", 12'b111_000_111_000, 0, 1'b0, 4'b1010, 1'b0, 1'b1);

        send_even("even_tie", 6'b11_10_00, 3'b100, 1'b1, 1'b1);
        send_even("even_clean", 6'b11_00_11, 3'b101, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/repetition_decoder.md
# repetition_decoder

Receive-side stage for `data_repeater`. It consumes the repeated bit stream MSB-first: N_REPT copies of each original bit, delivered serially one sample per valid cycle. It majority-votes each group of N_REPT copies and reassembles the original N_BITS_IN-bit word. It also reports whether any copy disagreed (a corrected error) and whether a frame was aborted.

## Interface
- N_REPT, default 3: copies per original bit; legal range 1..15. Odd values give strict majority.
- N_BITS_IN, default 8: width of the recovered word; legal range 1..64.
- i_clock, input, 1: sole clock, rising edge.
- i_reset, input, 1: asynchronous, active-high reset.
- i_valid, input, 1: i_bit (and i_sync) are sampled this cycle.
- i_bit, input, 1: one repeated-stream sample.
- i_sync, input, 1: qualified by i_valid. Marks the first sample of a frame.
- o_bits, output, N_BITS_IN: recovered word. MSB is the first group received.
- o_valid, output, 1: one-cycle pulse; o_bits, o_corrected and o_tie are new this cycle.
- o_corrected, output, 1: at least one group of the delivered word was not unanimous.
- o_tie, output, 1: at least one group had exactly N_REPT/2 ones. Only possible when N_REPT is even; such a group decodes to 0.
- o_abort, output, 1: one-cycle pulse; a partial frame was discarded.

## Operation
- States:
  - IDLE: waiting for a frame start.
  - COLLECT: accumulating samples of a frame.
- Counters and registers:
  - rep_cnt, width clog2(N_REPT+1).
  - ones_cnt, same width as rep_cnt.
  - bit_cnt, width clog2(N_BITS_IN+1).
  - Sticky corrected and tie flags for the frame in progress.
  - Shift register word, N_BITS_IN wide.
- IDLE:
  - i_valid=1 with i_sync=1: enter COLLECT. That sample counts as copy 0 of bit 0 (rep_cnt=1, ones_cnt=i_bit). Sticky flags clear.
  - i_valid=1 with i_sync=0: sample is discarded with no other effect.
- COLLECT, i_valid=1, i_sync=0:
  - rep_cnt increments and ones_cnt adds i_bit.
  - On the N_REPT-th copy of a group:
    - Vote: 1 if ones_total*2 > N_REPT, else 0. ones_total includes the current sample.
    - Word shifts left with the vote entering at bit 0.
    - Corrected flag sets if 0 < ones_total < N_REPT.
    - Tie flag sets if ones_total*2 == N_REPT.
    - rep_cnt and ones_cnt clear; bit_cnt increments.
  - On the final group (bit_cnt reaches N_BITS_IN): o_bits, o_corrected and o_tie load from the final values, o_valid pulses, and the state returns to IDLE.
- COLLECT, i_valid=0: nothing changes. Gaps of any length are legal.
- COLLECT, i_valid=1, i_sync=1 (resync): the partial frame is dropped and o_abort pulses. The sample restarts a frame exactly as from IDLE; the state stays COLLECT.
- A sync on the last sample of a frame is a resync. That frame is not delivered, and o_abort pulses.
- N_REPT=1: every sample is one bit; o_corrected and o_tie are always 0.
- o_bits, o_corrected and o_tie hold their values between o_valid pulses.

## Timing
- Reset:
  - All outputs 0 and state IDLE.
  - All counters and the shift register 0.
  - Reset takes effect asynchronously, mid-frame included; any partial frame is lost with no o_abort pulse.
- Latency: o_valid is high in the cycle after the clock edge that accepted the last sample of a frame.
- Back-to-back frames: a frame's last sample followed next cycle by i_sync is legal. The new frame's first sample is accepted in the same cycle o_valid is high.
- Throughput: one sample per cycle; one word per N_REPT*N_BITS_IN accepted samples.
- No backpressure: the consumer must sample o_bits on the o_valid pulse.

## Structure
- `repetition_pkg` (shared with `data_repeater`) holds:
  - State encoding constants: IDLE=1'b0, COLLECT=1'b1.
  - A function returning the majority threshold for N_REPT.
  - A clog2 helper.
- One sub-module, `majority_group`: owns rep_cnt and ones_cnt. Outputs group_done, vote, disagree and tie for the current sample. The top level owns the FSM, bit_cnt, the shift register and the output registers.

## Test plan
All scenarios use N_REPT=3 and N_BITS_IN=4 unless stated. Stream samples are written in order of arrival, first sample leftmost.
- Clean frame: stream 111 000 111 000, sync on the first sample, no gaps. Expect o_bits=4'b1010, o_corrected=0, o_valid high exactly 1 cycle, on the cycle after the 12th sample.
- Single-copy errors: stream 110 001 111 010. Expect o_bits=4'b1010, o_corrected=1. A following clean frame 000 000 000 111 gives o_bits=4'b0001, o_corrected=0.
- Gapped input: the clean frame with i_valid deasserted for 0–5 random cycles between samples. Expect o_bits=4'b1010, with o_valid one cycle after the last accepted sample.
- Resync and stray samples:
  - Sync again after 7 samples; expect o_abort pulses 1 cycle after that sample, and no o_valid from the first frame.
  - The following 000 000 000 111 frame (its first sample being the resync sample) gives o_bits=4'b0001.
  - Unsynced samples in IDLE produce no output.
- Reset mid-frame: assert i_reset asynchronously (between clock edges) after 5 samples.
  - Expect all outputs 0 immediately and no o_abort pulse.
  - A subsequent clean frame gives o_bits=4'b1010.
- Even repetition (N_REPT=2, N_BITS_IN=3): stream 11 10 00. Expect o_bits=3'b100, o_tie=1, o_corrected=1.
